// File: rtl/seg_serial_driver.sv
// Drives four 16-bit 7-segment words to a 74HC595-style chain, one word per digit.
// Build option: define SEG_BLANK_EN to blank the chain outputs except while a digit is held.
module seg_serial_driver #(
  parameter int CLK_DIV     = 2,
  parameter int HOLD_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] word_0,
  input  logic [15:0] word_1,
  input  logic [15:0] word_2,
  input  logic [15:0] word_3,
  output logic        sclk,
  output logic        sdata,
  output logic        rclk,
  output logic        oe_n,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_HOLD} state_t;

  localparam int BIT_CYC = 2 * CLK_DIV;
  localparam int CNT_MAX = (BIT_CYC > HOLD_CYCLES) ? BIT_CYC : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] C_BIT_LAST   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] C_HI_START   = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] C_LATCH_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_bit, w_bit_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [15:0]      r_sreg, w_sreg_nxt;
  logic [15:0]      w_word;
  logic             r_lit, w_lit_nxt;
  logic             w_oe_n_nxt;
  logic             r_sclk, r_sdata, r_rclk, r_oe_n, r_busy, r_frame_done;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_sreg_nxt  = r_sreg;
    w_lit_nxt   = r_lit;
    w_word      = word_0;

    case (r_idx)
      2'd1:    w_word = word_1;
      2'd2:    w_word = word_2;
      2'd3:    w_word = word_3;
      default: w_word = word_0;
    endcase

    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_sreg_nxt  = w_word;
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt  = '0;
          w_sreg_nxt = {r_sreg[14:0], 1'b0};
          if (r_bit == 4'd15) w_state_nxt = S_LATCH;
          else                w_bit_nxt   = r_bit + 4'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LATCH: begin
        if (r_cnt == C_LATCH_LAST) begin
          w_cnt_nxt   = '0;
          w_lit_nxt   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 2'd1;
          w_state_nxt = en ? S_LOAD : S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef SEG_BLANK_EN
    w_oe_n_nxt = !(w_lit_nxt && (w_state_nxt == S_HOLD));
`else
    w_oe_n_nxt = !w_lit_nxt;
`endif
  end

  // Outputs are registered from the next-state decode: glitch-free, yet aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_idx        <= '0;
      r_sreg       <= '0;
      r_lit        <= 1'b0;
      r_sclk       <= 1'b0;
      r_sdata      <= 1'b0;
      r_rclk       <= 1'b0;
      r_oe_n       <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge values.
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_idx        <= w_idx_nxt;
      r_sreg       <= w_sreg_nxt;
      r_lit        <= w_lit_nxt;
      r_sclk       <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt >= C_HI_START);
      r_sdata      <= (w_state_nxt == S_SHIFT) && w_sreg_nxt[15];
      r_rclk       <= (w_state_nxt == S_LATCH);
      r_oe_n       <= w_oe_n_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= (w_state_nxt == S_HOLD) && (w_cnt_nxt == C_HOLD_LAST) && (w_idx_nxt == 2'd3);
    end
  end

  assign sclk       = r_sclk;
  assign sdata      = r_sdata;
  assign rclk       = r_rclk;
  assign oe_n       = r_oe_n;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
